linear_ccd_sequencer: RTL and testbench

Parametrised timing generator for linear CCD sensors (ILX511B class and larger arrays). Drives the sensor clock and ROG (readout gate) through the sequence reset, integrate, latch and read out. During readout it emits one ADC-start strobe and one pixel index per pixel. It sits between the acquisition control logic and the ADC capture block. It adds free-running multi-frame mode, abort, latched integration time and start-overrun reporting.

---
 rtl/linear_ccd_sequencer_pkg.sv | 20 ++
 rtl/linear_ccd_sequencer_if.sv | 38 +++
 rtl/linear_ccd_sequencer_detect_rising_edge.sv | 17 +
 rtl/linear_ccd_sequencer.sv | 157 +++++++++++++++
 tb/tb_linear_ccd_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/linear_ccd_sequencer_pkg.sv
// Shared state encoding and ILX511B default timing for the linear CCD sequencer.
package ccd_seq_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRE_ROG   = 3'd1;
  localparam logic [2:0] ST_ROG_RESET = 3'd2;
  localparam logic [2:0] ST_INTEG     = 3'd3;
  localparam logic [2:0] ST_ROG_LATCH = 3'd4;
  localparam logic [2:0] ST_POST_ROG  = 3'd5;
  localparam logic [2:0] ST_READOUT   = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam int ILX_PIXELS       = 2087;
  localparam int ILX_CLK_DIV      = 4;
  localparam int ILX_SETUP_CYC    = 300;
  localparam int ILX_TICKS_PER_MS = 50000;

endpackage

// File: rtl/linear_ccd_sequencer_if.sv
// Control/status bundle between acquisition logic and the CCD sequencer.
// Optional strobe signal present when LINEAR_CCD_STROBE_EN is defined.
interface ccd_seq_if #(
  parameter int INT_W = 16
);
  logic             start;
  logic             cont_mode;
  logic             abort;
  logic [INT_W-1:0] int_time_ms;
  logic             ccd_clk;
  logic             ccd_rog;
  logic             adc_start;
  logic [15:0]      pix_idx;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
  logic             overrun;
`ifdef LINEAR_CCD_STROBE_EN
  logic             strobe;
`endif

  modport master (
    output start, cont_mode, abort, int_time_ms,
    input  ccd_clk, ccd_rog, adc_start, pix_idx, frame_start, frame_done, busy, overrun
`ifdef LINEAR_CCD_STROBE_EN
    , input strobe
`endif
  );

  modport slave (
    input  start, cont_mode, abort, int_time_ms,
    output ccd_clk, ccd_rog, adc_start, pix_idx, frame_start, frame_done, busy, overrun
`ifdef LINEAR_CCD_STROBE_EN
    , output strobe
`endif
  );

endinterface

// File: rtl/linear_ccd_sequencer_detect_rising_edge.sv
// Single-cycle rising-edge detector on a level input.
module detect_rising_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/linear_ccd_sequencer.sv
// Linear CCD timing generator: ROG/clock sequencing, per-pixel ADC strobes.
// Define LINEAR_CCD_STROBE_EN to add a light-source strobe high during ROG_LATCH.
module linear_ccd_sequencer
  import ccd_seq_pkg::*;
#(
  parameter int PIXELS       = ILX_PIXELS,
  parameter int CLK_DIV      = ILX_CLK_DIV,
  parameter int SETUP_CYC    = ILX_SETUP_CYC,
  parameter int TICKS_PER_MS = ILX_TICKS_PER_MS,
  parameter int ADC_PHASE    = 1,
  parameter int INT_W        = 16
)(
  input logic     sys_clk,
  input logic     sys_rst,
  ccd_seq_if.slave bus
);
  localparam int PH_MAX_A = (SETUP_CYC > TICKS_PER_MS) ? SETUP_CYC : TICKS_PER_MS;
  localparam int PH_MAX   = (PH_MAX_A > 2 * CLK_DIV) ? PH_MAX_A : 2 * CLK_DIV;
  localparam int PH_W     = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] TICK_LAST  = PH_W'(TICKS_PER_MS - 1);
  localparam logic [PH_W-1:0] PIXPH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] HALF       = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] ADC_PH     = PH_W'(ADC_PHASE);
  localparam logic [15:0]     PIX_LAST   = 16'(PIXELS - 1);

  function automatic logic [INT_W-1:0] sat_int(input logic [INT_W-1:0] v);
    return (v == '0) ? INT_W'(1) : v;
  endfunction

  state_t           st, st_nx, nxt;
  logic [PH_W-1:0]  ph, ph_nx;
  logic [INT_W-1:0] ms, ms_nx, lat, lat_nx;
  logic [15:0]      pix, pix_nx;
  logic             go, enter_pre, rise, ov_nx;
  logic             ccd_clk_q, ccd_rog_q, adc_q, fs_q, fd_q, busy_q, ov_q;
  logic [15:0]      pix_q;

  detect_rising_edge u_start_edge (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (bus.start),
    .rise (rise)
  );

  // Every state entry reloads the shared phase counter; INTEG and READOUT wrap it per ms/pixel.
  always_comb begin
    st_nx  = st;
    ph_nx  = ph + 1'b1;
    ms_nx  = ms;
    pix_nx = pix;
    lat_nx = lat;
    ov_nx  = ov_q;
    go     = 1'b0;
    nxt    = st;
    if (bus.abort) begin
      go  = 1'b1;
      nxt = ST_IDLE;
    end else begin
      if (rise && st != ST_IDLE) ov_nx = 1'b1;
      case (st)
        ST_IDLE: begin
          ph_nx = '0;
          if (rise) begin
            go    = 1'b1;
            nxt   = ST_PRE_ROG;
            ov_nx = 1'b0;
          end
        end
        ST_PRE_ROG:   if (ph == SETUP_LAST) begin go = 1'b1; nxt = ST_ROG_RESET; end
        ST_ROG_RESET: if (ph == SETUP_LAST) begin go = 1'b1; nxt = ST_INTEG;     end
        ST_INTEG: begin
          if (ph == TICK_LAST) begin
            ph_nx = '0;
            ms_nx = ms + 1'b1;
            if (ms == lat - 1'b1) begin go = 1'b1; nxt = ST_ROG_LATCH; end
          end
        end
        ST_ROG_LATCH: if (ph == SETUP_LAST) begin go = 1'b1; nxt = ST_POST_ROG; end
        ST_POST_ROG:  if (ph == SETUP_LAST) begin go = 1'b1; nxt = ST_READOUT;  end
        ST_READOUT: begin
          if (ph == PIXPH_LAST) begin
            ph_nx  = '0;
            pix_nx = pix + 1'b1;
            if (pix == PIX_LAST) begin go = 1'b1; nxt = ST_DONE; end
          end
        end
        ST_DONE: begin
          go  = 1'b1;
          nxt = bus.cont_mode ? ST_PRE_ROG : ST_IDLE;
        end
        default: begin go = 1'b1; nxt = ST_IDLE; end
      endcase
    end
    if (go) begin
      st_nx  = nxt;
      ph_nx  = '0;
      ms_nx  = '0;
      pix_nx = '0;
    end
    enter_pre = go && (nxt == ST_PRE_ROG);
    if (enter_pre) lat_nx = sat_int(bus.int_time_ms);
  end

  always_ff @(posedge sys_clk) lat <= lat_nx;

  // Outputs are registered from the next-state values so they align with the state they describe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st        <= ST_IDLE;
      ph        <= '0;
      ms        <= '0;
      pix       <= '0;
      ccd_clk_q <= 1'b1;
      ccd_rog_q <= 1'b1;
      adc_q     <= 1'b0;
      pix_q     <= '0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      st        <= st_nx;
      ph        <= ph_nx;
      ms        <= ms_nx;
      pix       <= pix_nx;
      ccd_clk_q <= !(st_nx == ST_READOUT && ph_nx < HALF);
      ccd_rog_q <= !(st_nx == ST_ROG_RESET || st_nx == ST_ROG_LATCH);
      adc_q     <= (st_nx == ST_READOUT) && (ph_nx == ADC_PH);
      pix_q     <= (st_nx == ST_READOUT) ? pix_nx : 16'd0;
      fs_q      <= enter_pre;
      fd_q      <= (st_nx == ST_DONE);
      busy_q    <= (st_nx != ST_IDLE);
      ov_q      <= ov_nx;
    end
  end

`ifdef LINEAR_CCD_STROBE_EN
  logic strobe_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) strobe_q <= 1'b0;
    else         strobe_q <= (st_nx == ST_ROG_LATCH);
  end
  assign bus.strobe = strobe_q;
`endif

  assign bus.ccd_clk     = ccd_clk_q;
  assign bus.ccd_rog     = ccd_rog_q;
  assign bus.adc_start   = adc_q;
  assign bus.pix_idx     = pix_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = ov_q;

endmodule

// File: tb/tb_linear_ccd_sequencer.sv
// Scoreboard bench for linear_ccd_sequencer with small test timing parameters.
module tb_linear_ccd_sequencer;
  localparam int P   = 4;
  localparam int CD  = 2;
  localparam int S   = 3;
  localparam int TPM = 5;
  localparam int ADC = 1;
  localparam int BIG = 1 << 30;

  typedef struct {
    int cyc;
    int kind;
    int pix;
  } ev_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [20:0] exp;
  } lv_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic fin = 1'b0;
  int   checks = 0;
  int   fails = 0;
  ev_t  ev_q[$];
  lv_t  lv_q[$];

  ccd_seq_if #(.INT_W(16)) bus ();

  linear_ccd_sequencer #(
    .PIXELS(P), .CLK_DIV(CD), .SETUP_CYC(S), .TICKS_PER_MS(TPM),
    .ADC_PHASE(ADC), .INT_W(16)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic add_ev(input int c, input int k, input int px);
    ev_t e;
    e.cyc = c; e.kind = k; e.pix = px;
    ev_q.push_back(e);
  endtask

  // Expected pulses of one frame whose frame_start lands in cycle f; events at or after cutoff are dropped.
  task automatic push_frame(input int f, input int t, input int cutoff);
    int r;
    r = f + 4 * S + t * TPM;
    if (f < cutoff) add_ev(f, 0, 0);
    for (int k = 0; k < P; k++)
      if (r + 2 * CD * k + ADC < cutoff) add_ev(r + 2 * CD * k + ADC, 1, k);
    if (r + 2 * CD * P < cutoff) add_ev(r + 2 * CD * P, 2, 0);
  endtask

  task automatic lvl(input int c, input int id, input logic ck, input logic rg,
                     input logic bz, input logic ov, input logic sb, input int px);
    lv_t e;
    logic s;
    s = sb;
`ifndef LINEAR_CCD_STROBE_EN
    s = 1'b0;
`endif
    e.cyc = c; e.id = id; e.exp = {ck, rg, bz, ov, s, 16'(px)};
    lv_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic ev_chk(input int k, input int px);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_evt kind=%0d cyc=%0d pix=%0d required=none", k, cyc, px);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.pix != px) begin
        fails++;
        $display("FAIL evt actual kind=%0d cyc=%0d pix=%0d required kind=%0d cyc=%0d pix=%0d",
                 k, cyc, px, e.kind, e.cyc, e.pix);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [20:0] act;
      logic        s;
      ev_t         m;
      lv_t         l;
      if (bus.frame_start) ev_chk(0, 0);
      if (bus.adc_start)   ev_chk(1, int'(bus.pix_idx));
      if (bus.frame_done)  ev_chk(2, 0);
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        m = ev_q.pop_front();
        checks++;
        fails++;
        $display("FAIL missed_evt kind=%0d at cyc=%0d now=%0d", m.kind, m.cyc, cyc);
      end
      s = 1'b0;
`ifdef LINEAR_CCD_STROBE_EN
      s = bus.strobe;
`endif
      act = {bus.ccd_clk, bus.ccd_rog, bus.busy, bus.overrun, s, bus.pix_idx};
      while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
        l = lv_q.pop_front();
        checks++;
        if (l.cyc != cyc || act !== l.exp) begin
          fails++;
          $display("FAIL lvl%0d cyc=%0d {clk,rog,busy,ov,strb,pix} actual=%h required=%h",
                   l.id, cyc, act, l.exp);
        end
      end
      if (fin) begin
        checks++;
        if (ev_q.size() != 0 || lv_q.size() != 0) begin
          fails++;
          $display("FAIL drain pending_evt=%0d pending_lvl=%0d required=0", ev_q.size(), lv_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
      end
    end
  end

  initial begin
    int f, r, g;
    bus.start = 1'b0;
    bus.cont_mode = 1'b0;
    bus.abort = 1'b0;
    bus.int_time_ms = 16'd2;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    lvl(cyc + 1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);

    // single frame, 2 ms
    bus.start = 1'b1;
    f = cyc + 1;
    r = f + 22;
    push_frame(f, 2, BIG);
    lvl(f + 3,  2, 1, 0, 1, 0, 0, 0);
    lvl(f + 6,  3, 1, 1, 1, 0, 0, 0);
    lvl(f + 16, 4, 1, 0, 1, 0, 1, 0);
    lvl(r + 4,  5, 0, 1, 1, 0, 0, 1);
    lvl(r + 7,  6, 1, 1, 1, 0, 0, 1);
    lvl(f + 38, 7, 1, 1, 1, 0, 0, 0);
    lvl(f + 39, 8, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(f + 42);

    // zero integration time saturates to 1 ms
    bus.int_time_ms = 16'd0;
    bus.start = 1'b1;
    f = cyc + 1;
    push_frame(f, 1, BIG);
    lvl(f + 10, 9,  1, 1, 1, 0, 0, 0);
    lvl(f + 11, 10, 1, 0, 1, 0, 1, 0);
    lvl(f + 34, 11, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(f + 37);

    // continuous mode; int time change mid-frame applies from the following frame
    bus.int_time_ms = 16'd2;
    bus.cont_mode = 1'b1;
    bus.start = 1'b1;
    f = cyc + 1;
    push_frame(f, 2, BIG);
    push_frame(f + 39, 2, BIG);
    push_frame(f + 78, 1, BIG);
    lvl(f + 39,  12, 1, 1, 1, 0, 0, 0);
    lvl(f + 112, 13, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(f + 45);
    bus.int_time_ms = 16'd1;
    wait_to(f + 80);
    bus.cont_mode = 1'b0;
    wait_to(f + 120);

    // abort in the second READOUT cycle
    bus.start = 1'b1;
    f = cyc + 1;
    r = f + 17;
    push_frame(f, 1, r + 2);
    lvl(r + 1, 14, 0, 1, 1, 0, 0, 0);
    lvl(r + 2, 15, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(r + 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_to(r + 30);

    // start during INTEG sets overrun without disturbing the frame
    bus.int_time_ms = 16'd2;
    bus.start = 1'b1;
    f = cyc + 1;
    push_frame(f, 2, BIG);
    lvl(f + 9,  16, 1, 1, 1, 1, 0, 0);
    lvl(f + 39, 17, 1, 1, 0, 1, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(f + 8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(f + 42);

    // accepted start clears overrun; reset mid ROG_LATCH
    bus.start = 1'b1;
    g = cyc + 1;
    push_frame(g, 2, g + 18);
    lvl(g,      18, 1, 1, 1, 0, 0, 0);
    lvl(g + 17, 19, 1, 0, 1, 0, 1, 0);
    lvl(g + 18, 20, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_to(g + 17);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);
    fin = 1'b1;
  end

endmodule
